fifo_multi_lane: RTL and testbench
==================================

# fifo_multi_lane

Parametrised first-word-fall-through FIFO that accepts up to WRITE_LANES entries and releases up to READ_LANES entries per clock, with a non-power-of-two depth. It is the successor to the single-entry FIFO. Its primary user is the bus-interface instruction queue: word fetches push 2 bytes, and the decoder peeks a window of up to 4 bytes and pops a variable number of them. Flush support is required so that the queue can be discarded on jumps.

## Interface
- WIDTH_DATA, 8, bits per entry
- DEPTH, 6, number of entries; any value ≥ 2, power of two not required
- WRITE_LANES, 2, maximum entries pushed per cycle (1..DEPTH)
- READ_LANES, 4, entries visible/poppable per cycle (1..DEPTH)

- clock  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  discard all contents this edge
- write_count  in  $clog2(WRITE_LANES+1)  entries to push this cycle (0 = none)
- write_data  in  WRITE_LANES*WIDTH_DATA  lane 0 (LSBs) enqueued first
- read_count  in  $clog2(READ_LANES+1)  entries to pop this cycle (0 = none)
- read_data  out  READ_LANES*WIDTH_DATA  lane 0 (LSBs) = oldest entry
- read_valid  out  READ_LANES  bit i = (count > i)
- count  out  $clog2(DEPTH+1)  occupied entries
- free  out  $clog2(DEPTH+1)  DEPTH − count
- empty, full  out  1  count==0 / count==DEPTH
- overflow, underflow  out  1  sticky error flags (only with the error macro; otherwise tied 0)

## Operation
- Storage: DEPTH×WIDTH_DATA register array, read pointer rd_ptr, write pointer wr_ptr, occupancy count. Pointers advance modulo DEPTH. Increments that wrap past DEPTH−1 must subtract DEPTH; power-of-two masking is not allowed.
- Push acceptance: accepted iff write_count ≤ free, evaluated on pre-edge state. Pops in the same cycle do not create space. Otherwise the whole push is rejected; partial pushes never occur.
- Pop acceptance: accepted iff read_count ≤ count on pre-edge state. Otherwise the whole pop is rejected and the contents are unchanged.
- Simultaneous push and pop: both are evaluated independently by the rules above. count_next = count + accepted_push − accepted_pop.
- Lanes with write_count ≤ lane index are ignored. write_count > WRITE_LANES and read_count > READ_LANES are treated as rejected.
- read_data lane i = storage[(rd_ptr+i) mod DEPTH] when read_valid[i], else 0.
- Flush: sets pointers and count to 0. It takes priority over the push and pop in the same cycle, which are discarded. Flush does not clear the error flags.
- Reset: highest priority. Clears pointers, count and error flags. Storage contents are not reset; they are masked by read_valid.

## Timing
- Reset values: count=0, free=DEPTH, empty=1, full=0, read_valid=0, read_data=0, overflow=0, underflow=0.
- read_data, read_valid, count, free, empty and full are combinational from registered state. There is zero-latency peek.
- A pushed entry appears on read_data the cycle after the push edge. Pop takes effect at the edge, and the next entries are shown in the following cycle.
- Full-to-empty and empty-to-full transitions are visible one cycle after the causing edge.
- Reset asserted mid-operation: the FIFO is empty the cycle after the edge, regardless of write_count, read_count or flush.

## Configuration
- FIFO_MULTI_LANE_ERROR_FLAGS_EN defined: overflow is set on any rejected push (write_count>0). underflow is set on any rejected pop (read_count>0). Both are sticky until reset.
- Not defined: both outputs are constant 0 and no flag registers are built. Push and pop acceptance are identical in both builds.

## Structure
- Package fifo_multi_lane_pkg: pointer-increment-mod-DEPTH function, and a width helper for the count/lane widths.
- Sub-module fifo_multi_lane_window: combinational rotator producing read_data/read_valid from the storage array, rd_ptr and count.
- Top holds the storage, pointers, acceptance logic and flags.

## Test plan
Defaults throughout; the error macro is defined unless noted.
- After reset, push 2 with {0x22,0x11} (lane0=0x11) → next cycle count=2, read_data lane0=0x11, lane1=0x22, read_valid=4'b0011, empty=0.
- Three pushes of 2 (0x01..0x06) → full=1, free=0. A 4th push of 1 → rejected, count stays 6, overflow=1.
- count=4 (0xA0..0xA3), push 2 (0xB0,0xB1) while popping 3 → count=3, lanes 0..2 = 0xA3,0xB0,0xB1.
- Wrap-around: repeatedly push 2 / pop 2 for 10 cycles with incrementing data → read order strictly increasing, no loss across the index 5→0 wrap.
- count=1, pop 2 → rejected, count=1, data unchanged, underflow=1. Rebuild without the macro → underflow stays 0, same data behaviour.
- Flush with a simultaneous push 2 at count=5 → next cycle count=0, empty=1, read_valid=0. Reset asserted mid-burst → same, and flags cleared.

Source files
------------

// File: rtl/fifo_multi_lane_pkg.sv
// fifo_multi_lane_pkg
// Shared helpers for the multi-lane FIFO:
//   ptr_add : advance a storage index modulo an arbitrary (non power-of-two) depth
//   cnt_w   : bit width needed to hold the values 0..n
package fifo_multi_lane_pkg;

  // Caller guarantees ptr < depth and inc <= depth, so one conditional
  // subtraction is enough to bring the sum back into range.
  function automatic int ptr_add(input int ptr, input int inc, input int depth);
    int sum;
    sum = ptr + inc;
    if (sum >= depth) sum = sum - depth;
    return sum;
  endfunction

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fifo_multi_lane_window.sv
// fifo_multi_lane_window
// Combinational read window: presents the READ_LANES oldest entries,
// starting at rd_ptr and wrapping modulo DEPTH. Lanes beyond the current
// occupancy read as zero with their valid bit clear.
// Ports:
//   mem        in  storage array (DEPTH x WIDTH_DATA)
//   rd_ptr     in  index of the oldest entry
//   count      in  occupied entries
//   read_data  out lane i = entry i positions after the oldest (lane 0 in LSBs)
//   read_valid out bit i = (count > i)
module fifo_multi_lane_window
  import fifo_multi_lane_pkg::*;
#(
  parameter int WIDTH_DATA = 8,
  parameter int DEPTH      = 6,
  parameter int READ_LANES = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic [WIDTH_DATA-1:0]            mem [DEPTH],
  input  logic [PW-1:0]                    rd_ptr,
  input  logic [CW-1:0]                    count,
  output logic [READ_LANES*WIDTH_DATA-1:0] read_data,
  output logic [READ_LANES-1:0]            read_valid
);

  always_comb begin
    read_data  = '0;
    read_valid = '0;
    for (int i = 0; i < READ_LANES; i++) begin
      if (i < int'(count)) begin
        read_valid[i] = 1'b1;
        read_data[i*WIDTH_DATA +: WIDTH_DATA] = mem[PW'(ptr_add(int'(rd_ptr), i, DEPTH))];
      end
    end
  end

endmodule

// File: rtl/fifo_multi_lane.sv
// fifo_multi_lane
// First-word-fall-through FIFO with multi-entry push and pop per clock and
// an arbitrary (non power-of-two) depth. Pushes and pops are all-or-nothing,
// both judged against the state before the edge.
// Ports:
//   clock, reset        single clock; synchronous active-high reset
//   flush               empty the FIFO this edge (overrides push/pop)
//   write_count/data    entries to push; lane 0 (LSBs) enqueued first
//   read_count          entries to pop
//   read_data/valid     zero-latency window onto the oldest READ_LANES entries
//   count, free         occupancy and remaining space
//   empty, full         occupancy == 0 / occupancy == DEPTH
//   overflow, underflow sticky rejected-push / rejected-pop flags
// Build option:
//   FIFO_MULTI_LANE_ERROR_FLAGS_EN  builds the sticky flags; without it both
//                                   flag outputs are tied to 0.
module fifo_multi_lane
  import fifo_multi_lane_pkg::*;
#(
  parameter int WIDTH_DATA  = 8,
  parameter int DEPTH       = 6,
  parameter int WRITE_LANES = 2,
  parameter int READ_LANES  = 4,
  localparam int WCW = cnt_w(WRITE_LANES),
  localparam int RCW = cnt_w(READ_LANES),
  localparam int CW  = cnt_w(DEPTH)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [WCW-1:0]                   write_count,
  input  logic [WRITE_LANES*WIDTH_DATA-1:0] write_data,
  input  logic [RCW-1:0]                   read_count,
  output logic [READ_LANES*WIDTH_DATA-1:0] read_data,
  output logic [READ_LANES-1:0]            read_valid,
  output logic [CW-1:0]                    count,
  output logic [CW-1:0]                    free,
  output logic                             empty,
  output logic                             full,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH_DATA-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         cnt;
  logic                  push_ok;
  logic                  pop_ok;
  logic [CW-1:0]         push_n;
  logic [CW-1:0]         pop_n;

  // Out-of-range counts are rejected; space freed by a same-cycle pop is not reused.
  assign push_ok = (int'(write_count) <= WRITE_LANES) &&
                   (int'(write_count) <= DEPTH - int'(cnt));
  assign pop_ok  = (int'(read_count) <= READ_LANES) &&
                   (int'(read_count) <= int'(cnt));
  assign push_n  = push_ok ? CW'(write_count) : '0;
  assign pop_n   = pop_ok  ? CW'(read_count)  : '0;

  // Storage is data only: never reset, stale entries are hidden by read_valid.
  always_ff @(posedge clock) begin
    if (!flush && push_ok) begin
      for (int i = 0; i < WRITE_LANES; i++) begin
        if (i < int'(write_count)) begin
          mem[PW'(ptr_add(int'(wr_ptr), i, DEPTH))] <= write_data[i*WIDTH_DATA +: WIDTH_DATA];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= PW'(ptr_add(int'(wr_ptr), int'(write_count), DEPTH));
      if (pop_ok)  rd_ptr <= PW'(ptr_add(int'(rd_ptr), int'(read_count), DEPTH));
      cnt <= cnt + push_n - pop_n;
    end
  end

`ifdef FIFO_MULTI_LANE_ERROR_FLAGS_EN
  logic ovf_q;
  logic udf_q;

  // A flushed cycle discards its push/pop without judging them.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (!flush) begin
      if (!push_ok && (write_count != '0)) ovf_q <= 1'b1;
      if (!pop_ok  && (read_count  != '0)) udf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign count = cnt;
  assign free  = CW'(DEPTH) - cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

  fifo_multi_lane_window #(
    .WIDTH_DATA (WIDTH_DATA),
    .DEPTH      (DEPTH),
    .READ_LANES (READ_LANES)
  ) u_window (
    .mem        (mem),
    .rd_ptr     (rd_ptr),
    .count      (cnt),
    .read_data  (read_data),
    .read_valid (read_valid)
  );

endmodule

// File: tb/tb_fifo_multi_lane.sv
// tb_fifo_multi_lane
// Directed scenarios plus a randomized run, all compared against a queue
// model of the FIFO kept in the bench.
module tb_fifo_multi_lane;

  localparam int W     = 8;
  localparam int DEPTH = 6;
  localparam int WL    = 2;
  localparam int RL    = 4;
  localparam int WCW   = 2;
  localparam int RCW   = 3;
  localparam int CW    = 3;

`ifdef FIFO_MULTI_LANE_ERROR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic [WCW-1:0]    write_count = '0;
  logic [WL*W-1:0]   write_data = '0;
  logic [RCW-1:0]    read_count = '0;
  logic [RL*W-1:0]   read_data;
  logic [RL-1:0]     read_valid;
  logic [CW-1:0]     count;
  logic [CW-1:0]     free;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: the FIFO is just an ordered list of entries.
  logic [W-1:0] q[$];
  bit           m_ovf = 1'b0;
  bit           m_udf = 1'b0;

  always #5 clk = ~clk;

  fifo_multi_lane dut (
    .clock       (clk),
    .reset       (reset),
    .flush       (flush),
    .write_count (write_count),
    .write_data  (write_data),
    .read_count  (read_count),
    .read_data   (read_data),
    .read_valid  (read_valid),
    .count       (count),
    .free        (free),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  function automatic logic [RL*W-1:0] exp_data();
    logic [RL*W-1:0] d;
    d = '0;
    for (int i = 0; i < RL; i++) if (i < q.size()) d[i*W +: W] = q[i];
    return d;
  endfunction

  function automatic logic [RL-1:0] exp_valid();
    logic [RL-1:0] v;
    v = '0;
    for (int i = 0; i < RL; i++) if (i < q.size()) v[i] = 1'b1;
    return v;
  endfunction

  // Apply one cycle of inputs, advance the model by the FIFO rules, and
  // leave the bench 1 time unit after the edge for sampling.
  task automatic step(input int wc, input logic [WL*W-1:0] wd, input int rc,
                      input bit fl, input bit rs);
    int  sz;
    bit  push_ok;
    bit  pop_ok;
    write_count = WCW'(wc);
    write_data  = wd;
    read_count  = RCW'(rc);
    flush       = fl;
    reset       = rs;
    @(posedge clk);
    sz = q.size();
    if (rs) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (fl) begin
      q.delete();
    end else begin
      push_ok = (wc <= WL) && (wc <= DEPTH - sz);
      pop_ok  = (rc <= RL) && (rc <= sz);
      if (pop_ok) for (int i = 0; i < rc; i++) void'(q.pop_front());
      if (push_ok) for (int i = 0; i < wc; i++) q.push_back(wd[i*W +: W]);
      if (!push_ok && wc > 0) m_ovf = 1'b1;
      if (!pop_ok && rc > 0) m_udf = 1'b1;
    end
    #1;
    reset       = 1'b0;
    flush       = 1'b0;
    write_count = '0;
    read_count  = '0;
  endtask

  task automatic test_reset();
    step(0, '0, 0, 1'b0, 1'b1);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (free !== 3'd6) begin errors++; $display("FAIL reset_free got=%0d exp=6", free); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got=%b%b exp=10", empty, full); end
    checks++; if (read_valid !== 4'b0000 || read_data !== 32'h0) begin errors++; $display("FAIL reset_read got=%b/%h exp=0000/00000000", read_valid, read_data); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", overflow, underflow); end
  endtask

  task automatic test_push_basic();
    step(0, '0, 0, 1'b0, 1'b1);
    step(2, 16'h2211, 0, 1'b0, 1'b0);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL push_count got=%0d exp=2", count); end
    checks++; if (read_data[15:0] !== 16'h2211) begin errors++; $display("FAIL push_lanes got=%h exp=2211", read_data[15:0]); end
    checks++; if (read_valid !== 4'b0011 || empty !== 1'b0) begin errors++; $display("FAIL push_valid got=%b empty=%b exp=0011 empty=0", read_valid, empty); end
  endtask

  task automatic test_full_overflow();
    step(0, '0, 0, 1'b0, 1'b1);
    step(2, 16'h0201, 0, 1'b0, 1'b0);
    step(2, 16'h0403, 0, 1'b0, 1'b0);
    step(2, 16'h0605, 0, 1'b0, 1'b0);
    checks++; if (full !== 1'b1 || free !== 3'd0) begin errors++; $display("FAIL full_flag got=full %b free %0d exp=full 1 free 0", full, free); end
    checks++; if (read_data !== 32'h04030201) begin errors++; $display("FAIL full_data got=%h exp=04030201", read_data); end
    step(1, 16'h0077, 0, 1'b0, 1'b0);
    checks++; if (count !== 3'd6) begin errors++; $display("FAIL ovf_count got=%0d exp=6", count); end
    checks++; if (overflow !== FLAGS) begin errors++; $display("FAIL ovf_flag got=%b exp=%b", overflow, FLAGS); end
  endtask

  task automatic test_simultaneous();
    step(0, '0, 0, 1'b0, 1'b1);
    step(2, 16'hA1A0, 0, 1'b0, 1'b0);
    step(2, 16'hA3A2, 0, 1'b0, 1'b0);
    step(2, 16'hB1B0, 3, 1'b0, 1'b0);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL simul_count got=%0d exp=3", count); end
    checks++; if (read_data !== 32'h00B1B0A3) begin errors++; $display("FAIL simul_data got=%h exp=00b1b0a3", read_data); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] nxt;
    logic [W-1:0] wv;
    step(0, '0, 0, 1'b0, 1'b1);
    step(2, 16'h0100, 0, 1'b0, 1'b0);
    nxt = 8'd0;
    wv  = 8'd2;
    for (int k = 0; k < 10; k++) begin
      checks++; if (read_data[15:0] !== {nxt + 8'd1, nxt} || count !== 3'd2) begin
        errors++; $display("FAIL wrap_order k=%0d got=%h cnt=%0d exp=%h cnt=2", k, read_data[15:0], count, {nxt + 8'd1, nxt});
      end
      step(2, {wv + 8'd1, wv}, 2, 1'b0, 1'b0);
      nxt = nxt + 8'd2;
      wv  = wv + 8'd2;
    end
  endtask

  task automatic test_underflow();
    step(0, '0, 0, 1'b0, 1'b1);
    step(1, 16'h005A, 0, 1'b0, 1'b0);
    step(0, '0, 2, 1'b0, 1'b0);
    checks++; if (count !== 3'd1 || read_data !== 32'h0000005A) begin errors++; $display("FAIL udf_data got=cnt %0d data %h exp=cnt 1 data 0000005a", count, read_data); end
    checks++; if (underflow !== FLAGS || overflow !== 1'b0) begin errors++; $display("FAIL udf_flag got=%b ovf=%b exp=%b ovf=0", underflow, overflow, FLAGS); end
  endtask

  task automatic test_flush();
    step(0, '0, 0, 1'b0, 1'b1);
    step(2, 16'h1211, 0, 1'b0, 1'b0);
    step(2, 16'h1413, 0, 1'b0, 1'b0);
    step(1, 16'h0015, 0, 1'b0, 1'b0);
    checks++; if (count !== 3'd5) begin errors++; $display("FAIL flush_pre got=%0d exp=5", count); end
    step(2, 16'h1716, 0, 1'b1, 1'b0);
    checks++; if (count !== 3'd0 || empty !== 1'b1 || read_valid !== 4'b0000) begin
      errors++; $display("FAIL flush_empty got=cnt %0d empty %b valid %b exp=cnt 0 empty 1 valid 0000", count, empty, read_valid);
    end
  endtask

  task automatic test_reset_mid();
    step(0, '0, 0, 1'b0, 1'b1);
    step(2, 16'h2120, 0, 1'b0, 1'b0);
    step(2, 16'h2322, 0, 1'b0, 1'b0);
    step(2, 16'h2524, 0, 1'b0, 1'b0);
    step(1, 16'h0026, 5, 1'b0, 1'b0);
    checks++; if (overflow !== FLAGS || underflow !== FLAGS) begin errors++; $display("FAIL mid_pre_flags got=%b%b exp=%b%b", overflow, underflow, FLAGS, FLAGS); end
    step(2, 16'h2827, 3, 1'b1, 1'b1);
    checks++; if (count !== 3'd0 || empty !== 1'b1 || read_valid !== 4'b0000) begin
      errors++; $display("FAIL mid_reset got=cnt %0d empty %b valid %b exp=cnt 0 empty 1 valid 0000", count, empty, read_valid);
    end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL mid_flags got=%b%b exp=00", overflow, underflow); end
  endtask

  task automatic test_random();
    int wc;
    int rc;
    bit fl;
    bit rs;
    step(0, '0, 0, 1'b0, 1'b1);
    for (int c = 0; c < 400; c++) begin
      wc = $urandom_range(0, 3);
      rc = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      fl = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 79) == 0);
      step(wc, WL*W'($urandom), rc, fl, rs);
      checks++; if (count !== CW'(q.size()) || free !== CW'(DEPTH - q.size())) begin
        errors++; $display("FAIL rnd_count c=%0d got=%0d/%0d exp=%0d/%0d", c, count, free, q.size(), DEPTH - q.size());
      end
      checks++; if (read_data !== exp_data() || read_valid !== exp_valid()) begin
        errors++; $display("FAIL rnd_window c=%0d got=%h/%b exp=%h/%b", c, read_data, read_valid, exp_data(), exp_valid());
      end
      checks++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
        errors++; $display("FAIL rnd_status c=%0d got=%b%b exp=%b%b", c, empty, full, q.size() == 0, q.size() == DEPTH);
      end
      checks++; if (overflow !== (FLAGS & m_ovf) || underflow !== (FLAGS & m_udf)) begin
        errors++; $display("FAIL rnd_flags c=%0d got=%b%b exp=%b%b", c, overflow, underflow, FLAGS & m_ovf, FLAGS & m_udf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_full_overflow();
    test_simultaneous();
    test_wrap();
    test_underflow();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
